int_to_float: RTL and testbench
===============================

# int_to_float

Converts a 32-bit two's-complement integer into an IEEE-754 single-precision value using round-to-nearest-even. It sits directly upstream of the floating-point adder and feeds either adder operand. It uses the same stb/ack handshake as the adder, so the two blocks chain with no glue logic. It is multi-cycle and processes one operand at a time.

## Interface
- No parameters.
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-high.
- input_a  input  32  signed integer operand.
- input_a_stb  input  1  producer asserts while input_a is valid.
- input_a_ack  output  1  registered; high while the block can accept an operand.
- output_z  output  32  IEEE single result, registered.
- output_z_stb  output  1  registered; high while output_z is valid.
- output_z_ack  input  1  consumer accepts output_z.

## Operation
- States: get_a, abs, normalise, round, pack, put_z.
- get_a
  - Drive input_a_ack <= 1.
  - When input_a_ack && input_a_stb in the same cycle: capture a, drop ack, go to abs.
- abs
  - If a == 0: z <= 32'h0, go to put_z.
  - Otherwise: z_s <= a[31]; value <= a[31] ? -a : a, as 32-bit unsigned, so 0x80000000 stays 0x80000000; z_e <= 31 (signed, 10 bits); go to normalise.
- normalise
  - If value[31] == 0: value <= value << 1 and z_e <= z_e - 1. Exactly one bit per cycle.
  - Otherwise:
    - z_m <= value[31:8]
    - guard <= value[7]
    - round_bit <= value[6]
    - sticky <= |value[5:0]
    - go to round.
- round
  - If guard && (round_bit | sticky | z_m[0]): z_m <= z_m + 1.
  - If that increment is taken and z_m == 24'hffffff: z_e <= z_e + 1, and z_m wraps to 0.
  - Go to pack.
- pack
  - z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0]}; go to put_z.
  - Exponent never exceeds 31, so no overflow, infinity, NaN or denormal path exists.
- put_z
  - output_z_stb <= 1; output_z <= z.
  - When output_z_stb && output_z_ack: output_z_stb <= 0, go to get_a.

## Timing
- Reset values: input_a_ack = 0, output_z_stb = 0, output_z = 0, state = get_a.
- input_a_ack first rises one cycle after rst deasserts.
- Reset asserted in any state abandons the conversion on that edge; any partial result is discarded.
- Handshake, both sides: a transfer occurs in a cycle where stb and ack are both high at the clock edge.
  - Producer holds input_a stable while stb is high and ack is low.
  - output_z and output_z_stb stay stable until ack.
- Latency, counted in edges from the input capture edge to the edge where output_z_stb goes high:
  - Nonzero input: 5 + lz edges, where lz = leading zeros of |a|.
  - Range: 5 edges for |a| = 2^31 up to 36 edges for |a| = 1.
  - Zero input: 2 edges.
- After output handshake: output_z_stb low the next cycle; input_a_ack high one cycle after that.
- No overlap: a new operand is never accepted while a result is pending.
- input_a_stb and output_z_ack held permanently high: each conversion still completes normally. Throughput is one result per latency + 3 cycles.

## Structure
- Shared package fpu_pkg holds:
  - state encoding for this block (3-bit);
  - constants EXP_BIAS = 127 and QNAN = 32'hffc00000;
  - a typedef for the {sign, exp[7:0], mant[22:0]} single-precision fields, reused by the adder.
- No sub-module needed; normalise and round stay inline.
- A shared fpu_round sub-module (guard/round/sticky to incremented mantissa and exponent carry) is a future refactor candidate, not part of this block.

## Test plan
- a = 1 -> 0x3F800000, output_z_stb 36 cycles after capture; a = -1 -> 0xBF800000.
- a = 0 -> 0x00000000 after 2 cycles; a = 0x80000000 (-2^31) -> 0xCF000000 after 5 cycles.
- a = 16777217 -> 0x4B800000 (tie, LSB even, no increment); a = 16777219 -> 0x4B800002 (tie rounds up to even).
- a = 0x7FFFFFFF -> 0x4F000000 (mantissa carry bumps exponent).
- Backpressure: hold output_z_ack low 10 cycles. Required: output_z and output_z_stb stable throughout, input_a_ack stays low, and the next operand is not accepted until after the output handshake.
- Assert rst mid-normalise with a = 5. Required: ack and stb low the next cycle, no output emitted. Then a = 5 -> 0x40A00000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: block state encodings, IEEE constants and field layout.
package fpu_pkg;

    localparam logic [2:0] S_GET_A     = 3'd0;
    localparam logic [2:0] S_ABS       = 3'd1;
    localparam logic [2:0] S_NORMALISE = 3'd2;
    localparam logic [2:0] S_ROUND     = 3'd3;
    localparam logic [2:0] S_PACK      = 3'd4;
    localparam logic [2:0] S_PUT_Z     = 3'd5;

    localparam logic [7:0]  EXP_BIAS = 8'd127;
    localparam logic [31:0] QNAN     = 32'hffc00000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

endpackage

// File: rtl/int_to_float.sv
// 32-bit signed integer to IEEE single converter, round-to-nearest-even.
// Multi-cycle, one bit of normalisation per cycle, stb/ack on both sides.
module int_to_float
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    logic [2:0]        r_state;
    logic [31:0]       r_a;
    logic [31:0]       r_value;
    logic              r_z_s;
    logic signed [9:0] r_z_e;
    logic [23:0]       r_z_m;
    logic              r_guard;
    logic              r_round;
    logic              r_sticky;
    fp32_t             r_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_GET_A;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= 32'h0;
            r_a          <= 32'h0;
            r_value      <= 32'h0;
            r_z_s        <= 1'b0;
            r_z_e        <= 10'sd0;
            r_z_m        <= 24'h0;
            r_guard      <= 1'b0;
            r_round      <= 1'b0;
            r_sticky     <= 1'b0;
            r_z          <= '0;
        end else begin
            unique case (r_state)
                S_GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        r_a         <= input_a;
                        input_a_ack <= 1'b0;
                        r_state     <= S_ABS;
                    end
                end
                S_ABS: begin
                    if (r_a == 32'h0) begin
                        r_z     <= '0;
                        r_state <= S_PUT_Z;
                    end else begin
                        // -2^31 negates to itself, which is already normalised
                        r_z_s   <= r_a[31];
                        r_value <= r_a[31] ? -r_a : r_a;
                        r_z_e   <= 10'sd31;
                        r_state <= S_NORMALISE;
                    end
                end
                S_NORMALISE: begin
                    if (!r_value[31]) begin
                        r_value <= r_value << 1;
                        r_z_e   <= r_z_e - 10'sd1;
                    end else begin
                        r_z_m    <= r_value[31:8];
                        r_guard  <= r_value[7];
                        r_round  <= r_value[6];
                        r_sticky <= |r_value[5:0];
                        r_state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_guard && (r_round || r_sticky || r_z_m[0])) begin
                        r_z_m <= r_z_m + 24'd1;
                        if (&r_z_m)
                            r_z_e <= r_z_e + 10'sd1;
                    end
                    r_state <= S_PACK;
                end
                S_PACK: begin
                    r_z.sign <= r_z_s;
                    r_z.exp  <= r_z_e[7:0] + EXP_BIAS;
                    r_z.mant <= r_z_m[22:0];
                    r_state  <= S_PUT_Z;
                end
                S_PUT_Z: begin
                    output_z_stb <= 1'b1;
                    output_z     <= r_z;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        r_state      <= S_GET_A;
                    end
                end
                default: r_state <= S_GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: vector table, scoreboard queue,
// backpressure, mid-conversion reset and streaming throughput sequences.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = 32'h0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] z,
                        output bit ok);
        int t;
        @(negedge clk);
        input_a     = a;
        input_a_stb = 1'b1;
        t = 0;
        while (!input_a_ack && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!input_a_ack) begin
            check("accept timeout", 32'd0, 32'd1);
            input_a_stb = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        sb.push_back(z);
        ok = 1'b1;
    endtask

    task automatic recv(input string name, input int lat, input int hold);
        int          k;
        logic [31:0] z0;
        logic [31:0] req;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!output_z_stb && k < 100);
        check({name, " latency"}, k, lat);
        if (!output_z_stb) return;
        z0 = output_z;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
            req = 32'hx;
        end else begin
            req = sb.pop_front();
            check(name, z0, req);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, " hold stb"}, output_z_stb, 1);
            check({name, " hold z"}, output_z, z0);
            check({name, " hold in ack"}, input_a_ack, 0);
        end
        @(negedge clk);
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
        check({name, " stb drop"}, output_z_stb, 0);
        check({name, " ack still low"}, input_a_ack, 0);
        @(posedge clk);
        #1;
        check({name, " ack rise"}, input_a_ack, 1);
    endtask

    initial begin
        bit ok;
        int k;
        int t1;
        int t2;

        vecs[0]  = '{32'h00000001, 32'h3F800000, 36};
        vecs[1]  = '{32'hFFFFFFFF, 32'hBF800000, 36};
        vecs[2]  = '{32'h00000000, 32'h00000000, 2};
        vecs[3]  = '{32'h80000000, 32'hCF000000, 5};
        vecs[4]  = '{32'd16777217, 32'h4B800000, 12};
        vecs[5]  = '{32'd16777219, 32'h4B800002, 12};
        vecs[6]  = '{32'h7FFFFFFF, 32'h4F000000, 6};
        vecs[7]  = '{32'd5,        32'h40A00000, 34};
        vecs[8]  = '{-32'sd5,      32'hC0A00000, 34};
        vecs[9]  = '{32'd1000,     32'h447A0000, 27};
        vecs[10] = '{32'd33554435, 32'h4C000001, 11};
        vecs[11] = '{32'd2,        32'h40000000, 35};
        vecs[12] = '{-32'sd16777219, 32'hCB800002, 12};

        repeat (3) @(posedge clk);
        #1;
        check("reset in ack", input_a_ack, 0);
        check("reset out stb", output_z_stb, 0);
        check("reset out z", output_z, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ack after reset", input_a_ack, 1);

        for (int i = 0; i < 13; i++) begin
            send(vecs[i].a, vecs[i].z, ok);
            if (ok)
                recv($sformatf("vec%0d", i), vecs[i].lat, (i == 6) ? 10 : 0);
        end

        // abandon a conversion of 5 while it is still shifting
        send(32'd5, 32'h40A00000, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset ack", input_a_ack, 0);
        check("midreset stb", output_z_stb, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("midreset ack rise", input_a_ack, 1);
        check("midreset no output", output_z_stb, 0);
        send(32'd5, 32'h40A00000, ok);
        if (ok) recv("after reset", 34, 0);

        // both handshakes held high: back-to-back conversions of 1000
        @(negedge clk);
        input_a      = 32'd1000;
        input_a_stb  = 1'b1;
        output_z_ack = 1'b1;
        k = 0;
        while (!output_z_stb && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        t1 = cyc;
        check("stream z1", output_z, 32'h447A0000);
        while (output_z_stb && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        while (!output_z_stb && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        t2 = cyc;
        input_a_stb = 1'b0;
        check("stream z2", output_z, 32'h447A0000);
        check("stream period", t2 - t1, 30);
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
        check("stream drained", output_z_stb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
